fetch_stage: RTL and testbench

- IF stage of the pipelined RV32 core, directly upstream of the instruction memory.
- Owns the PC register and drives the memory's address, write-enable and write-data lines.
- Samples the memory's combinational read data each cycle and registers {pc, insn, valid, fault} into the F/D pipeline register consumed by decode.
- Handles stall, redirect (branch/jump), halt and a one-cycle post-reset warm-up.

---
 rtl/core_pkg.sv | 21 ++
 rtl/fetch_pc_check.sv | 21 ++
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: reset vector, bubble instruction, fetch FSM encoding
// and the F/D pipeline register bundle that decode also consumes.
package core_pkg;

    localparam logic [31:0] RESET_PC = 32'h0100_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] pc;
        logic [31:0] insn;
    } fd_reg_t;

endpackage

// File: rtl/fetch_pc_check.sv
// Combinational PC legality check: word alignment plus an unsigned window test
// against [BASE, BASE+DEPTH-4]. Shared with the data-memory stage.
module fetch_pc_check #(
    parameter logic [31:0] BASE  = 32'h0100_0000,
    parameter logic [31:0] DEPTH = 32'd1048576
) (
    input  logic [31:0] i_pc,
    output logic        o_fault
);
    localparam logic [31:0] LAST = BASE + DEPTH - 32'd4;

    logic w_misaligned;
    logic w_below;
    logic w_above;

    assign w_misaligned = |i_pc[1:0];
    assign w_below      = (i_pc < BASE);
    assign w_above      = (i_pc > LAST);
    assign o_fault      = w_misaligned | w_below | w_above;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory and fills the F/D register.
// Priority in RUN: redirect > halt > stall > fetch; faulting PCs stick until redirected.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [31:0] MEM_DEPTH = 32'd1048576,
    parameter logic [31:0] NOP_INSN  = core_pkg::NOP_INSN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    output logic        imem_read_write,
    output logic [31:0] imem_data_in,
    input  logic [31:0] imem_data_out,
    output logic        fd_valid,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_insn,
    output logic        fd_fault,
    output logic        halted
);
    import core_pkg::*;

    fetch_state_e r_state;
    fd_reg_t      r_fd;
    logic [31:0]  r_pc;
    logic         r_halted;
    logic         w_fault;

    fetch_pc_check #(
        .BASE  (RESET_PC),
        .DEPTH (MEM_DEPTH)
    ) u_pc_check (
        .i_pc    (r_pc),
        .o_fault (w_fault)
    );

    assign imem_addr       = r_pc;
    assign imem_read_write = 1'b0;
    assign imem_data_in    = 32'd0;

    assign fd_valid = r_fd.valid;
    assign fd_fault = r_fd.fault;
    assign fd_pc    = r_fd.pc;
    assign fd_insn  = r_fd.insn;
    assign halted   = r_halted;

    // Bubbles keep fd_pc unchanged; only valid/fault/insn are forced.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_state  <= ST_WARMUP;
            r_fd     <= '{valid: 1'b0, fault: 1'b0, pc: 32'd0, insn: NOP_INSN};
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_WARMUP: begin
                    r_state <= ST_RUN;
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        r_pc       <= redirect_pc;
                        r_fd.valid <= 1'b0;
                        r_fd.fault <= 1'b0;
                        r_fd.insn  <= NOP_INSN;
                    end else if (halt_req) begin
                        r_state    <= ST_HALTED;
                        r_halted   <= 1'b1;
                        r_fd.valid <= 1'b0;
                        r_fd.fault <= 1'b0;
                        r_fd.insn  <= NOP_INSN;
                    end else if (!stall) begin
                        // A faulting PC is reported but never advanced, and imem data is dropped.
                        r_fd.valid <= 1'b1;
                        r_fd.pc    <= r_pc;
                        if (w_fault) begin
                            r_fd.fault <= 1'b1;
                            r_fd.insn  <= NOP_INSN;
                        end else begin
                            r_fd.fault <= 1'b0;
                            r_fd.insn  <= imem_data_out;
                            r_pc       <= r_pc + 32'd4;
                        end
                    end
                end
                ST_HALTED: begin
                    r_fd.valid <= 1'b0;
                    r_fd.fault <= 1'b0;
                    r_fd.insn  <= NOP_INSN;
                    if (redirect_valid) begin
                        r_pc     <= redirect_pc;
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_WARMUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic [31:0] imem_addr;
    logic        imem_read_write;
    logic [31:0] imem_data_in;
    logic [31:0] imem_data_out;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_insn;
    logic        fd_fault;
    logic        halted;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    wire [65:0] fd_bus = {fd_valid, fd_fault, fd_pc, fd_insn};

    fetch_stage dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt_req        (halt_req),
        .imem_addr       (imem_addr),
        .imem_read_write (imem_read_write),
        .imem_data_in    (imem_data_in),
        .imem_data_out   (imem_data_out),
        .fd_valid        (fd_valid),
        .fd_pc           (fd_pc),
        .fd_insn         (fd_insn),
        .fd_fault        (fd_fault),
        .halted          (halted)
    );

    always #5 clock = ~clock;

    // Two fixed words at the window base, otherwise addr ^ 0x5A5A0000.
    always_comb begin
        if (imem_addr == 32'h0100_0000)      imem_data_out = 32'hAAAA_0001;
        else if (imem_addr == 32'h0100_0004) imem_data_out = 32'hBBBB_0002;
        else                                 imem_data_out = imem_addr ^ 32'h5A5A_0000;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [65:0] exp;
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; halt_req = 1'b0;
        step(); step();
        exp = {1'b0, 1'b0, 32'd0, NOP};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL reset_fd: got %h want %h", fd_bus, exp); end
        n_cmp++;
        if (imem_addr !== 32'h0100_0000) begin n_fail++; $display("FAIL reset_pc: got %h want 01000000", imem_addr); end
        n_cmp++;
        if ({halted, imem_read_write, imem_data_in} !== 34'd0) begin
            n_fail++; $display("FAIL reset_ctl: got halted=%b rw=%b din=%h want 0/0/0", halted, imem_read_write, imem_data_in);
        end
    endtask

    task automatic test_warmup_fetch();
        logic [65:0] exp;
        reset = 1'b1;
        step();
        n_cmp++;
        if (fd_valid !== 1'b0 || imem_addr !== 32'h0100_0000) begin
            n_fail++; $display("FAIL warmup: got valid=%b pc=%h want 0/01000000", fd_valid, imem_addr);
        end
        step();
        exp = {1'b1, 1'b0, 32'h0100_0000, 32'hAAAA_0001};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL fetch0: got %h want %h", fd_bus, exp); end
        step();
        exp = {1'b1, 1'b0, 32'h0100_0004, 32'hBBBB_0002};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL fetch1: got %h want %h", fd_bus, exp); end
    endtask

    task automatic test_stall();
        logic [65:0] exp;
        stall = 1'b1;
        exp = {1'b1, 1'b0, 32'h0100_0004, 32'hBBBB_0002};
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (fd_bus !== exp || imem_addr !== 32'h0100_0008) begin
                n_fail++; $display("FAIL stall_hold%0d: got fd=%h pc=%h want fd=%h pc=01000008", i, fd_bus, imem_addr, exp);
            end
        end
        stall = 1'b0;
        step();
        exp = {1'b1, 1'b0, 32'h0100_0008, 32'h5B5A_0008};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL stall_resume: got %h want %h", fd_bus, exp); end
    endtask

    task automatic test_redirect_over_stall();
        logic [65:0] exp;
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0100_0100;
        step();
        redirect_valid = 1'b0; stall = 1'b0;
        n_cmp++;
        if (fd_valid !== 1'b0 || fd_insn !== NOP || fd_fault !== 1'b0 || imem_addr !== 32'h0100_0100) begin
            n_fail++; $display("FAIL redir_bubble: got v=%b f=%b insn=%h pc=%h want 0/0/00000013/01000100", fd_valid, fd_fault, fd_insn, imem_addr);
        end
        step();
        exp = {1'b1, 1'b0, 32'h0100_0100, 32'h5B5A_0100};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL redir_target: got %h want %h", fd_bus, exp); end
    endtask

    task automatic test_misaligned();
        logic [65:0] exp;
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0102;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (fd_valid !== 1'b0 || fd_fault !== 1'b0) begin
            n_fail++; $display("FAIL mis_bubble: got v=%b f=%b want 0/0", fd_valid, fd_fault);
        end
        exp = {1'b1, 1'b1, 32'h0100_0102, NOP};
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (fd_bus !== exp || imem_addr !== 32'h0100_0102) begin
                n_fail++; $display("FAIL mis_fault%0d: got fd=%h pc=%h want fd=%h pc=01000102", i, fd_bus, imem_addr, exp);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0000;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (fd_valid !== 1'b0 || fd_fault !== 1'b0) begin
            n_fail++; $display("FAIL mis_recover_bubble: got v=%b f=%b want 0/0", fd_valid, fd_fault);
        end
        step();
        exp = {1'b1, 1'b0, 32'h0100_0000, 32'hAAAA_0001};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL mis_recover: got %h want %h", fd_bus, exp); end
    endtask

    task automatic test_boundary();
        logic [65:0] exp;
        redirect_valid = 1'b1; redirect_pc = 32'h010F_FFF8;
        step();
        redirect_valid = 1'b0;
        step();
        exp = {1'b1, 1'b0, 32'h010F_FFF8, 32'h5B55_FFF8};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL bound_m8: got %h want %h", fd_bus, exp); end
        step();
        exp = {1'b1, 1'b0, 32'h010F_FFFC, 32'h5B55_FFFC};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL bound_last: got %h want %h", fd_bus, exp); end
        step();
        exp = {1'b1, 1'b1, 32'h0110_0000, NOP};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL bound_over: got %h want %h", fd_bus, exp); end
        redirect_valid = 1'b1; redirect_pc = 32'h00FF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        exp = {1'b1, 1'b1, 32'h00FF_FFFC, NOP};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL bound_under: got %h want %h", fd_bus, exp); end
    endtask

    task automatic test_halt();
        logic [65:0] exp;
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0000;
        step();
        redirect_valid = 1'b0;
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0; stall = 1'b1;
        n_cmp++;
        if (halted !== 1'b1 || fd_valid !== 1'b0 || fd_insn !== NOP) begin
            n_fail++; $display("FAIL halt_enter: got halted=%b v=%b insn=%h want 1/0/00000013", halted, fd_valid, fd_insn);
        end
        step();
        stall = 1'b0;
        n_cmp++;
        if (halted !== 1'b1 || fd_valid !== 1'b0 || imem_addr !== 32'h0100_0004) begin
            n_fail++; $display("FAIL halt_hold: got halted=%b v=%b pc=%h want 1/0/01000004", halted, fd_valid, imem_addr);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0100_0008;
        step();
        redirect_valid = 1'b0;
        n_cmp++;
        if (halted !== 1'b0 || fd_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_exit: got halted=%b v=%b want 0/0", halted, fd_valid);
        end
        step();
        exp = {1'b1, 1'b0, 32'h0100_0008, 32'h5B5A_0008};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL halt_resume: got %h want %h", fd_bus, exp); end
    endtask

    task automatic test_reset_midop();
        logic [65:0] exp;
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0100_0200; reset = 1'b0;
        step();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        exp = {1'b0, 1'b0, 32'd0, NOP};
        n_cmp++;
        if (fd_bus !== exp || imem_addr !== 32'h0100_0000) begin
            n_fail++; $display("FAIL rst_mid: got fd=%h pc=%h want fd=%h pc=01000000", fd_bus, imem_addr, exp);
        end
        step();
        n_cmp++;
        if (fd_valid !== 1'b0 || imem_addr !== 32'h0100_0000) begin
            n_fail++; $display("FAIL rst_warmup: got v=%b pc=%h want 0/01000000", fd_valid, imem_addr);
        end
        step();
        exp = {1'b1, 1'b0, 32'h0100_0000, 32'hAAAA_0001};
        n_cmp++;
        if (fd_bus !== exp) begin n_fail++; $display("FAIL rst_refetch: got %h want %h", fd_bus, exp); end
    endtask

    initial begin
        test_reset();
        test_warmup_fetch();
        test_stall();
        test_redirect_over_stall();
        test_misaligned();
        test_boundary();
        test_halt();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
